// File: rtl/scrambler_multimode_pkg.sv
// Shared definitions for the multimode x^58+x^39+1 scrambler.
// Mode encoding, polynomial geometry and the power-on seed.
package scrambler_multimode_pkg;

    localparam int POLY_LEN = 58;
    localparam int TAP      = 38;

    localparam logic [POLY_LEN-1:0] DEFAULT_SEED = 58'h3FF_FFFF_FFFF_FFFF;

    typedef logic [POLY_LEN-1:0] state_t;

    typedef enum logic [1:0] {
        MODE_BYPASS     = 2'd0,
        MODE_SCRAMBLE   = 2'd1,
        MODE_DESCRAMBLE = 2'd2,
        MODE_PRBS       = 2'd3
    } mode_e;

endpackage

// File: rtl/scrambler_multimode_core.sv
// Combinational per-beat bit loop: bit 0 first, S[0] is the newest bit.
// Bypass leaves both data and state untouched.
module scrambler_core
    import scrambler_multimode_pkg::*;
#(
    parameter int WIDTH = 257
) (
    input  mode_e            mode_i,
    input  state_t           state_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] result_o,
    output state_t           state_o
);

    state_t s;
    logic   t;
    logic   fb;

    always_comb begin
        s        = state_i;
        result_o = data_i;
        t        = 1'b0;
        fb       = 1'b0;
        if (mode_i != MODE_BYPASS) begin
            for (int i = 0; i < WIDTH; i++) begin
                t           = s[POLY_LEN-1] ^ s[TAP];
                result_o[i] = data_i[i] ^ t;
                case (mode_i)
                    MODE_SCRAMBLE:   fb = data_i[i] ^ t;
                    MODE_DESCRAMBLE: fb = data_i[i];
                    default:         fb = t;
                endcase
                s = {s[POLY_LEN-2:0], fb};
            end
        end
        state_o = s;
    end

endmodule

// File: rtl/scrambler_multimode.sv
// Multimode scrambler with a one-entry registered output stage.
// A coincident seed_load seeds the beat it arrives with.
module scrambler_multimode
    import scrambler_multimode_pkg::*;
#(
    parameter int                  WIDTH     = 257,
    parameter logic [POLY_LEN-1:0] SEED_INIT = DEFAULT_SEED
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    data_in,
    input  logic                seed_load,
    input  logic [POLY_LEN-1:0] seed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    data_out,
    output logic                state_zero
);

    state_t           s_q, s_d;
    state_t           start_w, core_s_w;
    logic [WIDTH-1:0] data_q, data_d, core_res_w;
    logic             valid_q, valid_d;
    logic             zero_q, zero_d;
    logic             accept_w;

    assign in_ready = !valid_q || out_ready;
    assign accept_w = in_valid && in_ready;
    assign start_w  = seed_load ? seed : s_q;

    scrambler_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .mode_i  (mode_e'(mode)),
        .state_i (start_w),
        .data_i  (data_in),
        .result_o(core_res_w),
        .state_o (core_s_w)
    );

    always_comb begin
        s_d     = s_q;
        data_d  = data_q;
        valid_d = valid_q;
        zero_d  = (s_q == '0);
        if (accept_w) begin
            s_d     = core_s_w;
            data_d  = core_res_w;
            valid_d = 1'b1;
        end else begin
            if (seed_load) s_d = seed;
            if (out_ready) valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= SEED_INIT;
            data_q  <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            s_q     <= s_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid  = valid_q;
    assign data_out   = data_q;
    assign state_zero = zero_q;

endmodule

// File: tb/tb_scrambler_multimode.sv
// Scrambler feeding descrambler, checked every cycle against a
// bit-stream reference model plus directed literal expectations.
module tb_scrambler_multimode;

    localparam int          W    = 257;
    localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode_a, mode_b;
    logic          a_valid;
    logic [W-1:0]  a_data;
    logic          sl_a, sl_b;
    logic [57:0]   seed_a, seed_b;
    logic          b_out_ready;

    logic          a_in_ready, a_out_valid, a_zero;
    logic [W-1:0]  a_data_out;
    logic          b_in_ready, b_out_valid, b_zero;
    logic [W-1:0]  b_data_out;

    int errors = 0;
    int checks = 0;
    int sent   = 0;
    int popped = 0;

    logic         chk_on     = 1'b0;
    logic         chain_on   = 1'b0;
    logic         mask_first = 1'b0;
    logic [W-1:0] q[$];

    logic [57:0]  ms[2];
    logic         mv[2];
    logic [W-1:0] md[2];
    logic         mz[2];

    always #5 clk = ~clk;

    scrambler_multimode #(.WIDTH(W), .SEED_INIT(SEED)) u_scr (
        .clk(clk), .rst(rst), .mode(mode_a),
        .in_valid(a_valid), .in_ready(a_in_ready), .data_in(a_data),
        .seed_load(sl_a), .seed(seed_a),
        .out_valid(a_out_valid), .out_ready(b_in_ready),
        .data_out(a_data_out), .state_zero(a_zero)
    );

    scrambler_multimode #(.WIDTH(W), .SEED_INIT(SEED)) u_des (
        .clk(clk), .rst(rst), .mode(mode_b),
        .in_valid(a_out_valid), .in_ready(b_in_ready), .data_in(a_data_out),
        .seed_load(sl_b), .seed(seed_b),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .data_out(b_data_out), .state_zero(b_zero)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the whole bit history as one stream, h[n] = h[n-58] ^ h[n-39].
    function automatic void beat(input logic [1:0] m, input logic [57:0] s,
                                 input logic [W-1:0] d,
                                 output logic [W-1:0] r, output logic [57:0] sn);
        logic h[0:57+W];
        logic t;
        r  = d;
        sn = s;
        if (m == 2'd0) return;
        for (int j = 0; j < 58; j++) h[j] = s[57-j];
        for (int i = 0; i < W; i++) begin
            t       = h[i] ^ h[i+19];
            r[i]    = d[i] ^ t;
            h[58+i] = (m == 2'd1) ? r[i] : (m == 2'd2) ? d[i] : t;
        end
        for (int k = 0; k < 58; k++) sn[k] = h[57+W-k];
    endfunction

    task automatic mstep(input int k, input logic [1:0] m, input logic acc,
                         input logic [W-1:0] din, input logic sl,
                         input logic [57:0] sd, input logic ordy);
        logic [W-1:0] r;
        logic [57:0]  sn, st;
        if (rst) begin
            ms[k] = SEED; mv[k] = 1'b0; md[k] = '0; mz[k] = 1'b0;
            return;
        end
        mz[k] = (ms[k] == '0);
        st    = sl ? sd : ms[k];
        if (acc) begin
            beat(m, st, din, r, sn);
            ms[k] = sn; md[k] = r; mv[k] = 1'b1;
        end else begin
            if (sl) ms[k] = sd;
            if (ordy) mv[k] = 1'b0;
        end
    endtask

    task automatic tick();
        logic r0, r1, a0, a1;
        logic [W-1:0] d1;
        @(posedge clk);
        r1 = !mv[1] || b_out_ready;
        r0 = !mv[0] || r1;
        a0 = a_valid && r0;
        a1 = mv[0] && r1;
        d1 = md[0];
        mstep(0, mode_a, a0, a_data, sl_a, seed_a, r1);
        mstep(1, mode_b, a1, d1, sl_b, seed_b, b_out_ready);
        #1;
    endtask

    task automatic send(input logic v, input logic [W-1:0] d, input logic bor);
        a_valid = v; a_data = d; b_out_ready = bor;
        #2;
        if (v && a_in_ready) sent++;
        tick();
    endtask

    task automatic do_reset();
        chain_on = 1'b0;
        rst = 1'b1; a_valid = 1'b0; sl_a = 1'b0; sl_b = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] r;
        logic [31:0]  x;
        for (int i = 0; i < W; i++) begin
            x = $urandom();
            r[i] = x[0];
        end
        return r;
    endfunction

    function automatic logic [57:0] rand58();
        logic [63:0] x;
        x = {$urandom(), $urandom()};
        return x[57:0];
    endfunction

    always @(negedge clk) begin
        logic [W-1:0] exp_d, ex;
        logic [57:0]  hd, em;
        if (chk_on) begin
            chk1("scr_valid", a_out_valid, mv[0]);
            chkw("scr_data", a_data_out, md[0]);
            chk1("scr_ready", a_in_ready, !mv[0] || !mv[1] || b_out_ready);
            chk1("scr_zero", a_zero, mz[0]);
            chk1("des_valid", b_out_valid, mv[1]);
            chkw("des_data", b_data_out, md[1]);
            chk1("des_ready", b_in_ready, !mv[1] || b_out_ready);
            chk1("des_zero", b_zero, mz[1]);
        end
        if (chain_on) begin
            if (b_out_valid && b_out_ready) begin
                if (q.size() == 0) begin
                    chk1("chain_underflow", 1'b1, 1'b0);
                end else begin
                    exp_d = q.pop_front();
                    popped++;
                    if (mask_first) begin
                        ex = b_data_out ^ exp_d;
                        hd = ex[57:0];
                        em = '0;
                        em[57:39] = '1;
                        chkw("chain_head_err", W'(hd), W'(em));
                        chkw("chain_tail", ex >> 58, '0);
                        mask_first = 1'b0;
                    end else begin
                        chkw("chain_data", b_data_out, exp_d);
                    end
                end
            end
            if (a_valid && a_in_ready) q.push_back(a_data);
        end
    end

    initial begin
        logic [W-1:0] d, sa, sb;
        rst = 1'b1; mode_a = 2'd0; mode_b = 2'd0; a_valid = 1'b0; a_data = '0;
        sl_a = 1'b0; sl_b = 1'b0; seed_a = '0; seed_b = '0; b_out_ready = 1'b1;
        tick();
        chk_on = 1'b1;
        do_reset();
        chk1("rst_ready", a_in_ready, 1'b1);
        chk1("rst_valid", a_out_valid, 1'b0);
        chkw("rst_data", a_data_out, '0);

        // PRBS from the reset seed: first 39 bits zero, bit 39 set
        mode_a = 2'd3;
        send(1'b1, '0, 1'b1);
        chk1("prbs_valid", a_out_valid, 1'b1);
        chkw("prbs_low", W'(a_data_out[38:0]), '0);
        chk1("prbs_b39", a_data_out[39], 1'b1);
        send(1'b0, '0, 1'b1);
        chk1("valid_drop", a_out_valid, 1'b0);

        sl_a = 1'b1; seed_a = 58'h1;
        send(1'b1, '0, 1'b1);
        sl_a = 1'b0;
        chkw("seed_beat", W'(a_data_out[38:0]), W'(39'h40_0000_0000));

        sl_a = 1'b1; seed_a = '0;
        send(1'b0, '0, 1'b1);
        sl_a = 1'b0;
        send(1'b0, '0, 1'b1);
        chk1("zero_flag", a_zero, 1'b1);
        for (int i = 0; i < 3; i++) begin
            d = rand_beat();
            send(1'b1, d, 1'b1);
            chkw("zero_passthru", a_data_out, d);
        end
        sl_a = 1'b1; seed_a = 58'h1;
        send(1'b0, '0, 1'b1);
        sl_a = 1'b0;
        send(1'b0, '0, 1'b1);
        chk1("zero_clear", a_zero, 1'b0);

        // reset while both stages are stalled
        mode_a = 2'd1;
        for (int i = 0; i < 4; i++) send(1'b1, rand_beat(), 1'b0);
        chk1("pre_rst_stall", a_out_valid && !a_in_ready, 1'b1);
        rst = 1'b1;
        send(1'b1, rand_beat(), 1'b0);
        rst = 1'b0;
        chk1("rst_scr_valid", a_out_valid, 1'b0);
        chk1("rst_des_valid", b_out_valid, 1'b0);
        mode_a = 2'd3;
        send(1'b1, '0, 1'b1);
        chkw("rst_seed_low", W'(a_data_out[38:0]), '0);
        chk1("rst_seed_b39", a_data_out[39], 1'b1);

        // scrambler -> descrambler round trip with a mid-stream stall
        do_reset();
        mode_a = 2'd1; mode_b = 2'd2;
        q.delete(); sent = 0; popped = 0;
        chain_on = 1'b1;
        for (int c = 0; c < 2000 && sent < 100; c++) begin
            if (sent == 50 && c < 1000) begin
                for (int k = 0; k < 3; k++) send(1'b1, rand_beat(), 1'b0);
                sa = a_data_out; sb = b_data_out;
                for (int k = 0; k < 5; k++) send(1'b1, rand_beat(), 1'b0);
                chk1("stall_ready", a_in_ready, 1'b0);
                chkw("stall_scr_data", a_data_out, sa);
                chkw("stall_des_data", b_data_out, sb);
                c = 1000;
            end
            if (sent < 100)
                send($urandom_range(0, 3) != 0, rand_beat(), $urandom_range(0, 3) != 0);
        end
        a_valid = 1'b0;
        for (int i = 0; i < 40 && q.size() > 0; i++) send(1'b0, '0, 1'b1);
        chk1("chain_sent", sent == 100, 1'b1);
        chk1("chain_drain", q.size() == 0, 1'b1);
        chk1("chain_count", popped == sent, 1'b1);

        // descrambler starts from a zero state: errors only in the first 58 bits
        do_reset();
        mode_a = 2'd1; mode_b = 2'd2;
        sl_b = 1'b1; seed_b = '0;
        send(1'b0, '0, 1'b1);
        sl_b = 1'b0;
        q.delete(); sent = 0; popped = 0;
        mask_first = 1'b1;
        chain_on = 1'b1;
        for (int i = 0; i < 20; i++) send(1'b1, rand_beat(), 1'b1);
        for (int i = 0; i < 40 && q.size() > 0; i++) send(1'b0, '0, 1'b1);
        chk1("resync_drain", q.size() == 0, 1'b1);
        chk1("resync_count", popped == 20, 1'b1);
        chain_on = 1'b0;

        // fully random traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            mode_a = 2'($urandom_range(0, 3));
            mode_b = 2'($urandom_range(0, 3));
            sl_a   = ($urandom_range(0, 31) == 0);
            sl_b   = ($urandom_range(0, 31) == 0);
            seed_a = ($urandom_range(0, 3) == 0) ? 58'h0 : rand58();
            seed_b = rand58();
            rst    = ($urandom_range(0, 199) == 0);
            send($urandom_range(0, 2) != 0, rand_beat(), $urandom_range(0, 2) != 0);
        end
        rst = 1'b0; sl_a = 1'b0; sl_b = 1'b0;
        send(1'b0, '0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scrambler_multimode.md
SCRAMBLER_MULTIMODE -- requirements
Module: scrambler_multimode

Interface
REQ-001 SHALL have parameter WIDTH, default 257, meaning bits per beat; legal range 1..1024.
REQ-002 SHALL have parameter SEED_INIT, default 58'h3FF_FFFF_FFFF_FFFF, meaning state value loaded at reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port mode, input, 2 bits: 0 bypass, 1 self-sync scramble, 2 self-sync descramble, 3 additive PRBS.
REQ-006 SHALL have port in_valid, input, 1 bit: data_in holds a beat.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 SHALL have port data_in, input, WIDTH bits: input beat; bit 0 is processed first.
REQ-009 SHALL have port seed_load, input, 1 bit: single-cycle pulse that loads seed into the state.
REQ-010 SHALL have port seed, input, 58 bits: new state value.
REQ-011 SHALL have port out_valid, output, 1 bit: data_out holds a beat.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream consumer takes the beat.
REQ-013 SHALL have port data_out, output, WIDTH bits: processed beat.
REQ-014 SHALL have port state_zero, output, 1 bit: registered flag, high when the state register is all zero.

Function
REQ-015 SHALL define the state S[57:0] with S[0] as the newest bit, and tap t = S[57] ^ S[38] (polynomial x^58+x^39+1).
REQ-016 SHALL process each bit i from 0 to WIDTH-1 as follows, with S shifting as {S[56:0], in} after each bit:
- mode 1: out = d ^ t; S shifts in out.
- mode 2: out = d ^ t; S shifts in d.
- mode 3: out = d ^ t; S shifts in t.
- mode 0: out = d; S unchanged.
REQ-017 SHALL accept a beat when in_valid && in_ready, with in_ready = !out_valid || out_ready (one-entry output register, no combinational in_valid->out_valid path).
REQ-018 SHALL register the result of an accepted beat into data_out on the next edge, giving a latency of exactly 1 cycle; out_valid is set on that edge.
REQ-019 SHALL clear out_valid on an edge where out_valid && out_ready && no beat is accepted.
REQ-020 SHALL hold data_out and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL update S only on an accepted beat or on seed_load; S is frozen while stalled or idle.
REQ-022 SHALL give seed_load precedence when it coincides with an accepted beat: the beat is processed starting from seed, not from the old S.
REQ-023 SHALL sample mode per accepted beat; a mode change between beats SHALL NOT alter S.
REQ-024 SHALL set state_zero on the edge after S becomes all zero; in mode 3 the zero state SHALL persist until seed_load or reset (no auto-recovery).

Reset
REQ-025 SHALL, on the edge where rst is high, set S = SEED_INIT, out_valid = 0, data_out = 0, state_zero = 0.
REQ-026 SHALL drive in_ready = 1 in the cycle after reset.
REQ-027 SHALL discard any beat held or being accepted when rst asserts mid-stream.
REQ-028 SHALL give rst priority over seed_load.

Structure
REQ-029 SHALL place the following in the shared AUI package, not locally: the mode encoding (enum), the constants POLY_LEN=58 and TAP=38, and the default seed.
REQ-030 SHALL implement the per-beat bit loop as a combinational sub-module scrambler_core (inputs: mode, state, data; outputs: result, next state), with handshake and registers in scrambler_multimode.

Verification
REQ-031 SHALL cover this scenario: reset, then mode 3 with data_in all zero, one beat -> data_out[38:0] = 0, data_out[39] = 1, out_valid high 1 cycle after acceptance.
REQ-032 SHALL cover this scenario: a mode-1 instance feeds a mode-2 instance, both at SEED_INIT, 100 random beats at WIDTH=257 -> the descrambler output equals the original data bit-exact.
REQ-033 SHALL cover this scenario: descrambler seeded with 58'h0 while the scrambler is at SEED_INIT -> output errors are confined to the first 58 bits, and all later bits are correct.
REQ-034 SHALL cover this scenario: out_ready held low for 5 cycles with in_valid high -> in_ready = 0, data_out and S unchanged; on release the beats continue with no loss or duplication.
REQ-035 SHALL cover this scenario: seed_load with seed = 0 in mode 3 -> state_zero = 1 on the next edge; data_out equals data_in thereafter until seed_load with 58'h1.
REQ-036 SHALL cover this scenario: seed_load coincident with an accepted beat, and rst asserted while out_valid && !out_ready -> the beat uses the new seed; after reset, out_valid = 0 and S = SEED_INIT.
